// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift datapath: default word length,
// receiver state encoding and bit-order selectors.
package shift_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bitcnt.sv
// Modulo-WIDTH bit counter with synchronous clear/enable and a last-bit flag.
// A clear together with an enable counts the enabled bit as bit 0 of a new word.
module shift_bitcnt
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_nxt;

   assign last = (cnt == LAST_CNT);

   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = en ? CW'(1) : '0;
      end else if (en) begin
         cnt_nxt = last ? '0 : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first
// and hands them out through a valid/ready holding register.
//
//   state | meaning
//   ------+-------------------------------------
//   IDLE  | no bits of the current word collected
//   SHIFT | 1..WIDTH-1 bits collected
module shift_deser
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             dir,
   input  logic             frame_start,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic             last;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic             dir_l;
   logic             dir_eff;
   logic             complete;
   logic             accept;
   logic             drop;

   shift_bitcnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bitcnt (
      .clk   (clk),
      .reset (reset),
      .clr   (frame_start),
      .en    (shift_en),
      .cnt   (cnt),
      .last  (last)
   );

   assign busy = (state == SHIFT);

   // Bit order is frozen at bit 0; a restart makes the current bit a new bit 0.
   always_comb begin
      dir_eff  = (frame_start || (cnt == '0)) ? dir : dir_l;
      sreg_nxt = (dir_eff == DIR_LSB_FIRST) ? {serial_in, sreg[WIDTH-1:1]}
                                            : {sreg[WIDTH-2:0], serial_in};
      complete = shift_en && !frame_start && last;
      accept   = complete && (!out_valid || out_ready);
      drop     = complete && out_valid && !out_ready;
   end

   always_comb begin
      state_nxt = state;
      if (frame_start) begin
         state_nxt = shift_en ? SHIFT : IDLE;
      end else if (shift_en) begin
         state_nxt = last ? IDLE : SHIFT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg      <= '0;
         dir_l     <= DIR_MSB_FIRST;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (shift_en) begin
            sreg  <= sreg_nxt;
            dir_l <= dir_eff;
         end
         if (accept) begin
            out_data  <= sreg_nxt;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver for the shift-register datapath. It is the receiving end of the serial stream produced by the parallel-load/shift register. It samples one bit per qualified clock, reassembles WIDTH-bit words in MSB-first or LSB-first order, and presents each completed word on a valid/ready output holding register. Words that cannot be accepted are dropped and recorded with a sticky overrun flag.

## Interface
Parameters:
- WIDTH, 8, word length in bits (≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- serial_in  in  1  serial data bit, sampled when shift_en=1
- shift_en  in  1  bit-valid qualifier; one bit per cycle it is high
- dir  in  1  0 = MSB-first, 1 = LSB-first; latched at bit 0 of each word
- frame_start  in  1  synchronous restart of word assembly; discards partial word
- out_ready  in  1  consumer accepts out_data when out_valid=1
- out_data  out  WIDTH  assembled word (holding register)
- out_valid  out  1  out_data holds an unconsumed word
- busy  out  1  partial word in progress (state SHIFT)
- overrun  out  1  sticky: a completed word was dropped
- clr_overrun  in  1  synchronous clear of overrun

## Operation
- States:
  - IDLE: no bits collected.
  - SHIFT: 1..WIDTH-1 bits collected.
- Transitions:
  - IDLE→SHIFT on the first shift_en.
  - SHIFT→IDLE when the WIDTH-th bit is sampled.
  - SHIFT→IDLE on frame_start without shift_en.
- Bit counter: cnt, width clog2(WIDTH).
  - Cleared on reset, frame_start and word completion.
  - Incremented on each sampled bit.
- Shift register sreg:
  - dir_l=0: sreg ← {sreg[WIDTH-2:0], serial_in}.
  - dir_l=1: sreg ← {serial_in, sreg[WIDTH-1:1]}.
- dir_l captured from dir on the bit where cnt=0. dir changes mid-word are ignored.
- Completion (WIDTH-th bit sampled), with the word = post-shift value:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: out_data ← word, out_valid stays/goes 1.
  - If out_valid=1 and out_ready=0: word dropped, out_data unchanged, overrun ← 1.
- Consume: out_valid=1 and out_ready=1 with no completion → out_valid ← 0. out_data is retained (don't-care).
- frame_start priority:
  - Overrides the partial word. cnt and state reset.
  - If shift_en=1 in the same cycle, serial_in becomes bit 0 of a new word (cnt←1, dir_l←dir, state SHIFT).
  - Does not affect out_valid/out_data/overrun.
- clr_overrun clears overrun. If a drop occurs in the same cycle, the set wins.
- WIDTH=8 counter wraps 7→0 at completion. No bit is lost between back-to-back words.

## Timing
- Reset (reset=0, asynchronous) values:
  - out_data=0, out_valid=0, busy=0, overrun=0.
  - cnt=0, sreg=0, state IDLE, dir_l=0.
- Reset deassertion is synchronized externally. The first sample is on the first rising edge with reset=1.
- Latency: out_valid rises the clock edge that samples the WIDTH-th bit, i.e. visible in the following cycle. No added pipeline stage.
- Throughput: one word per WIDTH cycles with shift_en held high, given out_ready=1.
- Handshake: out_data is stable while out_valid=1 and out_ready=0. Transfer occurs on an edge where both are 1.
- Reset mid-word: the partial word is lost and no flags are set.

## Structure
- Package shift_pkg:
  - WIDTH default.
  - State enum {IDLE, SHIFT}.
  - DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1.
  - Shared with the transmitting shift register and the benches.
- Sub-module shift_bitcnt:
  - Modulo-WIDTH counter with clear/enable.
  - Outputs a last-bit flag.
- Everything else stays in shift_deser.

## Test plan
- MSB-first: dir=0, bits 1,0,1,1,0,1,0,1 on 8 consecutive shift_en cycles, out_ready=1 → out_data=8'hB5, out_valid one cycle, overrun=0.
- LSB-first: dir=1, same bits → out_data=8'hAD. Toggling dir at bit 4 still yields 8'hAD.
- Backpressure: out_ready=0, send 8'hB5 then 8'h3C back-to-back → out_data stays 8'hB5, overrun=1 after the 16th bit. clr_overrun → overrun=0.
- Simultaneous consume and complete: out_ready=1 on the edge the second word completes → out_data=8'h3C, out_valid held 1, overrun=0.
- frame_start after 5 bits, with shift_en=1 carrying bit 1, then 7 more bits of 8'hFF → out_data=8'hFF, busy=1 throughout. Gaps in shift_en do not change the result.
- Assert reset after 3 bits → all outputs 0 immediately (asynchronous, before the next edge). A full word after release assembles correctly.
